fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a request/ready handshake to instruction memory (same handshake style as MainMem's Ready).
- Presents instruction, PC and PC+4 to IF/ID; honours the downstream stall and branch redirects resolved in EX/M.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_skid.sv | 38 +++
 rtl/fetch_stage.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state codes,
// default PC parameters, the alignment mask and small PC helpers.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned FETCH_PC_STEP  = 4;
  localparam logic [1:0]  MISALIGN_MASK  = 2'b11;

  // FETCH: request in flight at pc. HOLD: response parked in skid, no request.
  // DRAIN: finishing an abandoned-address request, data thrown away.
  // HALT: misaligned redirect seen, only reset leaves.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & MISALIGN_MASK) != 2'b00;
  endfunction

  // 32-bit unsigned add; wraps past 32'hFFFF_FFFF.
  function automatic logic [31:0] pc_add(input logic [31:0] pc, input int unsigned step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry {ir, pc} skid buffer. Catches a memory response that lands
// while the downstream register is stalled. flush wins over load, load over unload.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] ld_ir,
  input  logic [31:0] ld_pc,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        full
);

  fetch_entry_t entry_q;

  // Entry storage and occupancy flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_q <= '0;
      full    <= 1'b0;
    end else if (flush) begin
      full    <= 1'b0;
    end else if (load) begin
      entry_q <= '{ir: ld_ir, pc: ld_pc};
      full    <= 1'b1;
    end else if (unload) begin
      full    <= 1'b0;
    end
  end

  assign ir = entry_q.ir;
  assign pc = entry_q.pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, runs the
// req/ready handshake to instruction memory, honours stall and EX/M redirects.
// Optional FETCH_STATS_EN adds fetch_count / imem_wait_cycles counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic        valid_out,
  output logic        fetch_misalign
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] imem_wait_cycles
`endif
);

  logic [1:0]  state, state_d;
  logic [31:0] pc_q, pc_d, pc_inc;
  logic [31:0] tgt_q, tgt_d;
  logic        drain_halt_q, drain_halt_d;   // DRAIN ends in HALT, not FETCH
  logic        br_bad, mis_set;
  logic        ld_mem, ld_skid, clr_valid;
  logic        skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0] skid_ir, skid_pc;

  assign br_bad      = is_misaligned(branch_target);
  assign pc_inc      = pc_add(pc_q, PC_STEP);
  // Request drops the moment reset is asserted; address always tracks pc,
  // which is frozen while a request is outstanding.
  assign imem_req    = reset && ((state == ST_FETCH) || (state == ST_DRAIN));
  assign imem_addr   = pc_q;
  assign next_pc_out = pc_add(pc_out, PC_STEP);
  assign skid_flush  = take_branch;

  fetch_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .flush  (skid_flush),
    .ld_ir  (imem_data),
    .ld_pc  (pc_q),
    .ir     (skid_ir),
    .pc     (skid_pc),
    .full   (skid_full)
  );

  // Next-state / control decode; redirect outranks everything in every state
  always_comb begin
    state_d      = state;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    drain_halt_d = drain_halt_q;
    mis_set      = 1'b0;
    ld_mem       = 1'b0;
    ld_skid      = 1'b0;
    clr_valid    = 1'b0;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (take_branch) begin
          clr_valid = 1'b1;
          if (br_bad) begin
            mis_set = 1'b1;
            if (imem_ready) begin
              state_d = ST_HALT;
            end else begin
              state_d      = ST_DRAIN;
              drain_halt_d = 1'b1;
            end
          end else if (imem_ready) begin
            pc_d = branch_target;
          end else begin
            tgt_d        = branch_target;
            drain_halt_d = 1'b0;
            state_d      = ST_DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (stall_in) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            ld_mem = 1'b1;
          end
        end else if (!stall_in) begin
          clr_valid = 1'b1;
        end
      end
      ST_HOLD: begin
        if (take_branch) begin
          clr_valid = 1'b1;
          if (br_bad) begin
            mis_set = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = branch_target;
            state_d = ST_FETCH;
          end
        end else if (!stall_in && skid_full) begin
          ld_skid     = 1'b1;
          skid_unload = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (take_branch) begin
          clr_valid = 1'b1;
          if (br_bad) begin
            mis_set      = 1'b1;
            drain_halt_d = 1'b1;
          end else begin
            tgt_d = branch_target;
          end
        end
        if (imem_ready) begin
          if (drain_halt_d) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = tgt_d;
            state_d = ST_FETCH;
          end
          drain_halt_d = 1'b0;
        end
      end
      ST_HALT: begin
        clr_valid = take_branch;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // FSM state, PC, pending redirect target and sticky misalign flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_FETCH;
      pc_q           <= RESET_PC;
      tgt_q          <= '0;
      drain_halt_q   <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      state        <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      drain_halt_q <= drain_halt_d;
      if (mis_set) fetch_misalign <= 1'b1;
    end
  end

  // IF/ID-facing output registers; a flush clears valid even under stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_out    <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (clr_valid) begin
      valid_out <= 1'b0;
    end else if (ld_mem) begin
      ir_out    <= imem_data;
      pc_out    <= pc_q;
      valid_out <= 1'b1;
    end else if (ld_skid) begin
      ir_out    <= skid_ir;
      pc_out    <= skid_pc;
      valid_out <= 1'b1;
    end
  end

`ifdef FETCH_STATS_EN
  logic delivered, waiting;
  assign delivered = ld_mem | ld_skid;
  assign waiting   = imem_req & ~imem_ready;

  // Saturating delivery and memory-wait counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count      <= '0;
      imem_wait_cycles <= '0;
    end else begin
      if (delivered && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (waiting && (imem_wait_cycles != 32'hFFFF_FFFF))
        imem_wait_cycles <= imem_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard that tracks the expected
// program-order stream (pc sequence, redirects, halts) and memory handshake rules.
module tb_fetch_stage;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        stall  = 1'b0;
  logic        br     = 1'b0;
  logic [31:0] tgt    = '0;
  int          lat    = 1;   // cycles the address is held before ready
  int          wcnt   = 0;

  logic        imem_req, imem_ready, valid, misalign;
  logic [31:0] imem_addr, imem_data, ir_out, pc_out, next_pc;
  logic        req_w, valid_w, mis_w;
  logic [31:0] addr_w, data_w, ir_w, pc_w, npc_w;
`ifdef FETCH_STATS_EN
  logic [31:0] fc, wc, fc_w, wc_w;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: ready after lat cycles of a held request, data is a function of address
  assign imem_ready = imem_req && (wcnt >= lat - 1);
  assign imem_data  = mem_word(imem_addr);
  always @(posedge clk)
    if (!rst_n || !imem_req || imem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;

  assign data_w = mem_word(addr_w);

  fetch_stage u_dut (
    .clk(clk), .reset(rst_n), .stall_in(stall), .take_branch(br), .branch_target(tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .ir_out(ir_out), .pc_out(pc_out), .next_pc_out(next_pc), .valid_out(valid),
    .fetch_misalign(misalign)
`ifdef FETCH_STATS_EN
    , .fetch_count(fc), .imem_wait_cycles(wc)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(rst_n), .stall_in(1'b0), .take_branch(1'b0), .branch_target(32'h0),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ready(req_w), .imem_data(data_w),
    .ir_out(ir_w), .pc_out(pc_w), .next_pc_out(npc_w), .valid_out(valid_w),
    .fetch_misalign(mis_w)
`ifdef FETCH_STATS_EN
    , .fetch_count(fc_w), .imem_wait_cycles(wc_w)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: snapshot at each negedge, judge the next edge's effect at the following one
  logic        p_reset = 1'b0, p_stall = 1'b0, p_br = 1'b0, p_req = 1'b0, p_ready = 1'b0, p_valid = 1'b0;
  logic [31:0] p_tgt = '0, p_addr = '0, p_ir = '0, p_pc = '0;
  logic [31:0] exp_next = '0;
  bit          mis_seen = 1'b0;

  always @(negedge clk) begin
    if (!p_reset) begin
      chk("sb_rst_valid", valid, 0);
      chk("sb_rst_ir", ir_out, 0);
      chk("sb_rst_pc", pc_out, 0);
      chk("sb_rst_misalign", misalign, 0);
      chk("sb_rst_req", imem_req, rst_n);
      chk("sb_rst_addr", imem_addr, 0);
      exp_next = 32'h0;
      mis_seen = 1'b0;
    end else begin
      if (p_br) begin
        chk("sb_flush_valid", valid, 0);
        if (p_tgt[1:0] != 2'b00) mis_seen = 1'b1;
        else if (!mis_seen) exp_next = p_tgt;
      end else if (p_stall) begin
        chk("sb_stall_ir", ir_out, p_ir);
        chk("sb_stall_pc", pc_out, p_pc);
        chk("sb_stall_valid", valid, p_valid);
      end else if (valid) begin
        chk("sb_pc_order", pc_out, exp_next);
        chk("sb_ir_data", ir_out, mem_word(pc_out));
        exp_next = exp_next + 32'd4;
      end
      if (mis_seen) chk("sb_halt_valid", valid, 0);
      chk("sb_misalign", misalign, mis_seen);
      if (rst_n && p_req && !p_ready) begin
        chk("sb_req_held", imem_req, 1);
        chk("sb_addr_held", imem_addr, p_addr);
      end else if (rst_n && mis_seen) begin
        chk("sb_halt_req", imem_req, 0);
      end
    end
    chk("sb_next_pc", next_pc, pc_out + 32'd4);
    p_reset = rst_n;  p_stall = stall;  p_br = br;  p_tgt = tgt;
    p_req = imem_req; p_ready = imem_ready; p_addr = imem_addr;
    p_ir = ir_out;    p_pc = pc_out;    p_valid = valid;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; lat = l;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // 0-wait stream plus wrap instance
    do_reset(1);
    chk("A_rst_valid", valid, 0);
    chk("A_rst_req", imem_req, 1);
    chk("A_rst_addr", imem_addr, 0);
    chk("W_rst_addr", addr_w, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("A_pc", pc_out, i * 4);
      chk("A_valid", valid, 1);
      if (i == 0) begin
        chk("A_ir0", ir_out, 32'hFFFF_0000);
        chk("W_pc0", pc_w, 32'hFFFF_FFFC);
        chk("W_next_pc_wrap", npc_w, 32'h0);
        chk("W_addr_wrap", addr_w, 32'h0);
      end
      if (i == 1) begin
        chk("W_pc1", pc_w, 32'h0);
`ifdef FETCH_STATS_EN
        chk("W_fetch_count", fc_w, 2);
`endif
      end
    end
`ifdef FETCH_STATS_EN
    chk("A_fetch_count", fc, 4);
    chk("A_wait", wc, 0);
`endif

    // 3-cycle memory latency on 0x4
    do_reset(1);
    cyc();
    lat = 3;
    chk("B_addr0", imem_addr, 32'h4);
    chk("B_valid0", valid, 1);
    for (int k = 1; k < 3; k++) begin
      cyc();
      chk("B_addr", imem_addr, 32'h4);
      chk("B_req", imem_req, 1);
      chk("B_bubble", valid, 0);
    end
    cyc();
    chk("B_valid", valid, 1);
    chk("B_pc", pc_out, 32'h4);
    chk("B_ir", ir_out, 32'hFFFB_0004);
`ifdef FETCH_STATS_EN
    chk("B_fetch_count", fc, 2);
    chk("B_wait", wc, 2);
`endif

    // stall while response arrives -> HOLD, then skid word, then resume
    do_reset(1);
    cyc();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("C_req_off", imem_req, 0);
      chk("C_pc_frozen", pc_out, 32'h0);
      chk("C_valid_frozen", valid, 1);
    end
    stall = 1'b0;
    cyc();
    chk("C_skid_pc", pc_out, 32'h4);
    chk("C_skid_ir", ir_out, 32'hFFFB_0004);
    chk("C_resume_addr", imem_addr, 32'h8);
`ifdef FETCH_STATS_EN
    chk("C_fetch_count", fc, 2);
`endif
    cyc();
    chk("C_next_pc", pc_out, 32'h8);

    // redirect to 0x100 while slow request to 0x8 outstanding
    do_reset(1);
    cyc();
    cyc();
    lat = 3; br = 1'b1; tgt = 32'h100;
    cyc();
    br = 1'b0;
    chk("D_flush", valid, 0);
    chk("D_addr_held", imem_addr, 32'h8);
    chk("D_req", imem_req, 1);
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk("D_bubble", valid, 0);
      chk("D_addr", imem_addr, (k < 2) ? 32'h8 : 32'h100);
    end
    cyc();
    chk("D_valid", valid, 1);
    chk("D_pc", pc_out, 32'h100);
`ifdef FETCH_STATS_EN
    chk("D_fetch_count", fc, 3);
    chk("D_wait", wc, 4);
`endif

    // misaligned redirect -> HALT, then reset recovers
    do_reset(1);
    cyc();
    br = 1'b1; tgt = 32'h102;
    cyc();
    br = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("E_misalign", misalign, 1);
      chk("E_req_off", imem_req, 0);
      chk("E_valid", valid, 0);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("E_rst_misalign", misalign, 0);
    chk("E_rst_req", imem_req, 0);
    rst_n = 1'b1;
    cyc();
    chk("E_restart_pc", pc_out, 32'h0);
    chk("E_restart_valid", valid, 1);

    // misaligned redirect with request pending: drain first, then halt
    do_reset(3);
    br = 1'b1; tgt = 32'h6;
    cyc();
    br = 1'b0;
    chk("E2_misalign", misalign, 1);
    chk("E2_req_drain", imem_req, 1);
    chk("E2_addr", imem_addr, 32'h0);
    cyc();
    chk("E2_req_drain1", imem_req, 1);
    cyc();
    chk("E2_req_halt", imem_req, 0);

    // redirect taken while in HOLD
    do_reset(1);
    cyc();
    stall = 1'b1;
    cyc();
    br = 1'b1; tgt = 32'h40;
    cyc();
    br = 1'b0; stall = 1'b0;
    chk("F_flush", valid, 0);
    chk("F_addr", imem_addr, 32'h40);
    cyc();
    chk("F_pc", pc_out, 32'h40);
    chk("F_valid", valid, 1);

    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
